// File: rtl/tank_ctrl_pkg.sv
// Direction/track code constants, mode and priority encodings, and the stick-to-track maps.
// Pure combinational helpers; no latency, no flow control.
package tank_ctrl_pkg;

   // Direction codes are {up,down,left,right}.
   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_UP    = 4'b1000;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0001;

   // Track codes are {L_fw,L_bk,R_fw,R_bk}.
   localparam logic [3:0] TRK_STOP     = 4'b0000;
   localparam logic [3:0] TRK_FWD      = 4'b1010;
   localparam logic [3:0] TRK_BACK     = 4'b0101;
   localparam logic [3:0] TRK_FW_LEFT  = 4'b0010;
   localparam logic [3:0] TRK_FW_RIGHT = 4'b1000;
   localparam logic [3:0] TRK_BK_RIGHT = 4'b0100;
   localparam logic [3:0] TRK_BK_LEFT  = 4'b0001;
   localparam logic [3:0] TRK_SPIN_R   = 4'b1001;
   localparam logic [3:0] TRK_SPIN_L   = 4'b0110;

   typedef enum logic {
      MODE_TANK = 1'b0,
      MODE_DUAL = 1'b1
   } mode_e;

   // Which member of an opposite pair {a,b} was accepted most recently.
   typedef enum logic [1:0] {
      PREF_NONE = 2'd0,
      PREF_A    = 2'd1,
      PREF_B    = 2'd2
   } pref_e;

   function automatic logic [3:0] tank_map(input logic [3:0] dir);
      logic [3:0] trk;
      case (dir)
         DIR_UP   | DIR_LEFT:  trk = TRK_FW_LEFT;
         DIR_UP:               trk = TRK_FWD;
         DIR_UP   | DIR_RIGHT: trk = TRK_FW_RIGHT;
         DIR_RIGHT:            trk = TRK_SPIN_R;
         DIR_DOWN | DIR_RIGHT: trk = TRK_BK_RIGHT;
         DIR_DOWN:             trk = TRK_BACK;
         DIR_DOWN | DIR_LEFT:  trk = TRK_BK_LEFT;
         DIR_LEFT:             trk = TRK_SPIN_L;
         default:              trk = TRK_STOP;
      endcase
      return trk;
   endfunction

   function automatic logic [3:0] dual_map(input logic [3:0] dir);
      return {dir[3], dir[2], dir[0], dir[1]};
   endfunction

   function automatic logic is_pivot(input logic [3:0] trk);
      return (trk == TRK_SPIN_R) || (trk == TRK_SPIN_L);
   endfunction

   function automatic logic [1:0] resolve_pair(input logic [1:0] held, input pref_e pref);
      logic [1:0] res;
      res = held;
      if (held == 2'b11) begin
         case (pref)
            PREF_A:  res = 2'b10;
            PREF_B:  res = 2'b01;
            default: res = 2'b00;
         endcase
      end
      return res;
   endfunction

   function automatic pref_e next_pref(input logic [1:0] rise, input pref_e pref);
      pref_e nxt;
      case (rise)
         2'b11:   nxt = PREF_NONE;
         2'b10:   nxt = PREF_A;
         2'b01:   nxt = PREF_B;
         default: nxt = pref;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/tank_stick_channel.sv
// One player: sync, debounce, opposite-pair resolve, track map and slow-pivot gate.
// Input step to trk_o in 2+DEB_CYCLES+1 clock edges; no backpressure.
module tank_stick_channel
   import tank_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES   = 4,
   parameter int PIVOT_PERIOD = 4,
   parameter int PIVOT_ON     = 2
) (
   input  logic       clk_sys,
   input  logic       Reset_n,
   input  logic [3:0] dir_i,
   input  logic       mode_i,
   input  logic       pivot_slow_i,
   output logic [3:0] trk_o,
   output logic       pivot_o
);

   localparam int PH_W = (PIVOT_PERIOD > 1) ? $clog2(PIVOT_PERIOD) : 1;
   localparam logic [7:0]    DEB_LAST = 8'(DEB_CYCLES - 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PIVOT_PERIOD - 1);
   localparam logic [PH_W:0]   ON_W    = (PH_W + 1)'(PIVOT_ON);

   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   logic [3:0][7:0]  cnt_q, cnt_d;
   logic [3:0]       acc_q, acc_d;
   pref_e            pref_ud_q, pref_ud_d;
   pref_e            pref_lr_q, pref_lr_d;
   logic [3:0]       code_q, code_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [3:0]       trk_q, trk_d;
   logic             pivot_q, pivot_d;

   logic [3:0]       rise;
   logic [3:0]       res;

   always_comb begin
      sync1_d = dir_i;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      for (int b = 0; b < 4; b++) begin
         if (sync2_q[b] == acc_q[b]) begin
            cnt_d[b] = '0;
         end else if (cnt_q[b] == DEB_LAST) begin
            cnt_d[b] = '0;
            acc_d[b] = sync2_q[b];
         end else begin
            cnt_d[b] = cnt_q[b] + 8'd1;
         end
      end

      // Priority tracks the newest acceptance; resolution uses the already-accepted state.
      rise      = acc_d & ~acc_q;
      pref_ud_d = next_pref(rise[3:2], pref_ud_q);
      pref_lr_d = next_pref(rise[1:0], pref_lr_q);
      res       = {resolve_pair(acc_q[3:2], pref_ud_q), resolve_pair(acc_q[1:0], pref_lr_q)};

      code_d  = (mode_e'(mode_i) == MODE_DUAL) ? dual_map(res) : tank_map(res);
      pivot_d = is_pivot(code_d);

      if (!pivot_d || (code_d != code_q)) begin
         phase_d = '0;
      end else if (phase_q == PH_LAST) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + PH_W'(1);
      end

      trk_d = code_d;
      if (pivot_slow_i && pivot_d && ({1'b0, phase_d} >= ON_W)) begin
         trk_d = TRK_STOP;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!Reset_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         pref_ud_q <= PREF_NONE;
         pref_lr_q <= PREF_NONE;
         code_q    <= '0;
         phase_q   <= '0;
         trk_q     <= '0;
         pivot_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         pref_ud_q <= pref_ud_d;
         pref_lr_q <= pref_lr_d;
         code_q    <= code_d;
         phase_q   <= phase_d;
         trk_q     <= trk_d;
         pivot_q   <= pivot_d;
      end
   end

   assign trk_o   = trk_q;
   assign pivot_o = pivot_q;

endmodule

// File: rtl/tank_stick_encoder.sv
// Multi-player tank stick encoder: one independent channel per player.
// Latency 2+DEB_CYCLES+1 edges from input step to trk_o; no backpressure.
module tank_stick_encoder
   import tank_ctrl_pkg::*;
#(
   parameter int NUM_PLAYERS  = 2,
   parameter int DEB_CYCLES   = 4,
   parameter int PIVOT_PERIOD = 4,
   parameter int PIVOT_ON     = 2
) (
   input  logic                     clk_sys,
   input  logic                     Reset_n,
   input  logic [4*NUM_PLAYERS-1:0] dir_i,
   input  logic [NUM_PLAYERS-1:0]   mode_i,
   input  logic                     pivot_slow_i,
   output logic [4*NUM_PLAYERS-1:0] trk_o,
   output logic [NUM_PLAYERS-1:0]   pivot_o
);

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      tank_stick_channel #(
         .DEB_CYCLES   (DEB_CYCLES),
         .PIVOT_PERIOD (PIVOT_PERIOD),
         .PIVOT_ON     (PIVOT_ON)
      ) u_chan (
         .clk_sys      (clk_sys),
         .Reset_n      (Reset_n),
         .dir_i        (dir_i[4*p +: 4]),
         .mode_i       (mode_i[p]),
         .pivot_slow_i (pivot_slow_i),
         .trk_o        (trk_o[4*p +: 4]),
         .pivot_o      (pivot_o[p])
      );
   end

endmodule

// File: tb/tb_tank_stick_encoder.sv
// Directed stimulus with a cycle-tagged expectation queue drained by an independent monitor.
module tb_tank_stick_encoder;

   logic       clk_sys = 1'b0;
   logic       Reset_n;
   logic [7:0] dir_i;
   logic [1:0] mode_i;
   logic       pivot_slow_i;
   logic [7:0] trk_o;
   logic [1:0] pivot_o;

   tank_stick_encoder #(
      .NUM_PLAYERS  (2),
      .DEB_CYCLES   (4),
      .PIVOT_PERIOD (4),
      .PIVOT_ON     (2)
   ) dut (
      .clk_sys      (clk_sys),
      .Reset_n      (Reset_n),
      .dir_i        (dir_i),
      .mode_i       (mode_i),
      .pivot_slow_i (pivot_slow_i),
      .trk_o        (trk_o),
      .pivot_o      (pivot_o)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] trk;
      logic [1:0] piv;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   k;

   task automatic expect_at(input int c, input logic [7:0] t, input logic [1:0] p, input string nm);
      exp_t e;
      e.cyc  = c;
      e.trk  = t;
      e.piv  = p;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Monitor: compare every expectation tagged with the current cycle.
   always @(negedge clk_sys) begin
      int i;
      i = 0;
      while (i < exp_q.size()) begin
         if (exp_q[i].cyc == cyc) begin
            checks++;
            if (trk_o === exp_q[i].trk && pivot_o === exp_q[i].piv) begin
               passes++;
            end else begin
               $display("FAIL %s @cyc %0d: trk_o=%b pivot_o=%b, required trk_o=%b pivot_o=%b",
                        exp_q[i].name, cyc, trk_o, pivot_o, exp_q[i].trk, exp_q[i].piv);
            end
            exp_q.delete(i);
         end else if (exp_q[i].cyc < cyc) begin
            checks++;
            $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)",
                     exp_q[i].name, exp_q[i].cyc, cyc);
            exp_q.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      Reset_n      = 1'b0;
      dir_i        = 8'h00;
      mode_i       = 2'b00;
      pivot_slow_i = 1'b0;
      step(3);
      expect_at(cyc, 8'h00, 2'b00, "reset_hold");
      Reset_n = 1'b1;
      step(2);
      expect_at(cyc, 8'h00, 2'b00, "reset_idle");

      // Hold up: forward after exactly 7 edges.
      dir_i = 8'h08; k = cyc;
      expect_at(k + 6, 8'h00, 2'b00, "up_early");
      expect_at(k + 7, 8'h0A, 2'b00, "up_fwd");
      step(10);
      dir_i = 8'h00; k = cyc;
      expect_at(k + 6, 8'h0A, 2'b00, "up_rel_early");
      expect_at(k + 7, 8'h00, 2'b00, "up_rel");
      step(10);

      // Three-cycle glitch on up is rejected.
      dir_i = 8'h08; k = cyc;
      step(3);
      dir_i = 8'h00;
      expect_at(k + 7, 8'h00, 2'b00, "glitch_7");
      expect_at(k + 8, 8'h00, 2'b00, "glitch_8");
      expect_at(k + 10, 8'h00, 2'b00, "glitch_10");
      step(12);

      // Right, then left later: left wins; release left restores right.
      dir_i = 8'h01; k = cyc;
      expect_at(k + 7, 8'h09, 2'b01, "right_spin");
      step(20);
      dir_i = 8'h03; k = cyc;
      expect_at(k + 6, 8'h09, 2'b01, "left_pending");
      expect_at(k + 7, 8'h06, 2'b01, "left_wins");
      step(10);
      dir_i = 8'h01; k = cyc;
      expect_at(k + 6, 8'h06, 2'b01, "left_rel_early");
      expect_at(k + 7, 8'h09, 2'b01, "right_restored");
      step(10);
      dir_i = 8'h00;
      step(10);

      // Up and down accepted together resolve to neither; later press wins.
      dir_i = 8'h0C; k = cyc;
      expect_at(k + 7, 8'h00, 2'b00, "updown_same");
      expect_at(k + 9, 8'h00, 2'b00, "updown_same_hold");
      step(10);
      dir_i = 8'h08; k = cyc;
      expect_at(k + 6, 8'h00, 2'b00, "down_rel_early");
      expect_at(k + 7, 8'h0A, 2'b00, "up_after_down_rel");
      step(10);
      dir_i = 8'h0C; k = cyc;
      expect_at(k + 7, 8'h05, 2'b00, "down_over_up");
      step(10);
      dir_i = 8'h00;
      step(10);

      // Slow pivot: 2 on / 2 off, pivot_o constant; direction change restarts phase.
      pivot_slow_i = 1'b1;
      dir_i = 8'h01; k = cyc;
      expect_at(k + 7,  8'h09, 2'b01, "slow_p0");
      expect_at(k + 8,  8'h09, 2'b01, "slow_p1");
      expect_at(k + 9,  8'h00, 2'b01, "slow_p2");
      expect_at(k + 10, 8'h00, 2'b01, "slow_p3");
      expect_at(k + 11, 8'h09, 2'b01, "slow_p0b");
      expect_at(k + 12, 8'h09, 2'b01, "slow_p1b");
      expect_at(k + 13, 8'h00, 2'b01, "slow_p2b");
      expect_at(k + 14, 8'h00, 2'b01, "slow_p3b");
      step(17);
      dir_i = 8'h03; k = cyc;
      expect_at(k + 6,  8'h09, 2'b01, "slow_before_flip");
      expect_at(k + 7,  8'h06, 2'b01, "slow_flip_p0");
      expect_at(k + 8,  8'h06, 2'b01, "slow_flip_p1");
      expect_at(k + 9,  8'h00, 2'b01, "slow_flip_p2");
      expect_at(k + 10, 8'h00, 2'b01, "slow_flip_p3");
      expect_at(k + 11, 8'h06, 2'b01, "slow_flip_p0b");
      step(12);
      dir_i = 8'h00;
      step(10);
      dir_i = 8'h08; k = cyc;
      expect_at(k + 7,  8'h0A, 2'b00, "slow_fwd_0");
      expect_at(k + 9,  8'h0A, 2'b00, "slow_fwd_2");
      expect_at(k + 10, 8'h0A, 2'b00, "slow_fwd_3");
      step(12);
      dir_i = 8'h00;
      pivot_slow_i = 1'b0;
      step(10);

      // DUAL mode up+right, then switch to TANK while held.
      mode_i = 2'b01;
      dir_i  = 8'h09; k = cyc;
      expect_at(k + 7, 8'h0A, 2'b00, "dual_up_right");
      step(10);
      mode_i = 2'b00; k = cyc;
      expect_at(k,     8'h0A, 2'b00, "mode_sw_same");
      expect_at(k + 1, 8'h08, 2'b00, "mode_sw_tank");
      step(4);
      dir_i = 8'h00;
      step(10);

      // Player 1 down, player 0 idle; one-cycle reset pulse.
      dir_i = 8'h40; k = cyc;
      expect_at(k + 7, 8'h50, 2'b00, "p1_back");
      step(10);
      Reset_n = 1'b0; k = cyc;
      step(1);
      Reset_n = 1'b1;
      expect_at(k + 1, 8'h00, 2'b00, "pulse_reset");
      expect_at(k + 7, 8'h00, 2'b00, "pulse_relatch_early");
      expect_at(k + 8, 8'h50, 2'b00, "pulse_restored");
      step(12);
      dir_i = 8'h41; k = cyc;
      expect_at(k + 6, 8'h50, 2'b00, "p0_spin_early");
      expect_at(k + 7, 8'h59, 2'b01, "p0_spin_p1_back");
      step(10);
      dir_i = 8'h00; k = cyc;
      expect_at(k + 7, 8'h00, 2'b00, "all_released");
      step(8);

      for (int n = 0; n < 50 && exp_q.size() > 0; n++) step(1);
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
